calc_add_pipe: RTL and testbench
================================

Name: calc_add_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit adder used by the K-means distance/centroid datapath.
- Splits the carry chain into STAGES registered segments, so a wide add closes timing at high add_clk rates.
- Adds subtract mode, signed-overflow detection, optional saturation, and a valid/ready handshake with full-pipeline stall.
- Sits between the distance-difference unit and the centroid accumulators. Throughput is one operation per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be divisible by STAGES.
- STAGES, 4, number of pipeline segments; latency in cycles (1..WIDTH).
- SAT, 0, 1 = clamp signed overflow to the signed max/min value; 0 = wrap.

Ports:
- add_clk  in  1  clock, rising edge.
- add_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- op_sub  in  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry out (add); in sub, 1 = no borrow.
- ovf  out  1  signed overflow of this result.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, out_valid = 0, s = 0, cout = 0, ovf = 0. In-flight operations are discarded. in_ready = 1 from the first cycle after release.
- Pipeline enable: en = ~out_valid | out_ready. in_ready = en, which is combinational and independent of in_valid. A beat is accepted when in_valid & in_ready.
- When en = 0, every stage holds, including data and valid bits. No bubbles are inserted and no beats are dropped.
- Operand prep at capture (stage 0):
  - b_eff = op_sub ? ~b : b.
  - c0 = op_sub ? ~cin : cin.
  - op_sub is carried alongside the data.
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k (1..STAGES) adds segment bits [k*SEG-1:(k-1)*SEG] of a and b_eff, plus the carry registered by stage k-1.
  - Lower result segments and the not-yet-used upper operand segments are delayed in shift registers.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES-1 when there are no stalls. Each stall cycle adds one cycle.
- cout = carry out of the MSB segment.
- ovf = carry-into-MSB XOR carry-out-of-MSB. The final stage therefore computes the MSB bit separately, or equivalently computes it from sign bits: ovf = (a[W-1] == b_eff[W-1]) & (s_raw[W-1] != a[W-1]).
- SAT = 1 and ovf = 1: s = a[W-1] ? {1,0...0} : {0,1...1}. cout is still the raw carry, and ovf still reads 1.
- SAT = 0: s = raw result modulo 2^WIDTH.
- Output regs hold while out_valid & ~out_ready. Outputs are stable until accepted.
- STAGES = 1 degenerates to one registered full-width adder with the same handshake.
- Simultaneous accept and output-drain in the same cycle is the normal case: full throughput.

Decomposition:
- Package calc_pkg holds:
  - opcode constants OP_ADD = 1'b0, OP_SUB = 1'b1;
  - the default widths;
  - the SEG derivation function.
- Sub-module calc_add_seg: a SEG-bit registered segment adder with enable, async reset, carry in/out, and valid passthrough. It is instantiated STAGES times by a generate loop.
- The top level holds the operand/result delay lines, the overflow and saturation logic, and the handshake.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Basic add, stall-free: a=50, b=13, cin=0 -> s=63, cout=0, ovf=0, out_valid at the 4th edge after accept. Next beat a=105, b=256 -> s=361 on the following cycle.
- Carry across segments: a=0x0000FFFF, b=1 -> s=0x00010000. Also a=0xFFFFFFFF, b=1 -> s=0, cout=1, ovf=0.
- Subtract: a=5, b=7, cin=0, op_sub=1 -> s=0xFFFFFFFE, cout=0. Also a=7, b=5, cin=1 -> s=1, cout=1.
- Overflow: a=0x7FFFFFFF, b=1 -> ovf=1, with s=0x80000000 (SAT=0) or s=0x7FFFFFFF (SAT=1). Also a=0x80000000, b=1, op_sub -> s=0x7FFFFFFF (SAT=0) or 0x80000000 (SAT=1), ovf=1.
- Backpressure: 10 back-to-back beats (a=i, b=100) with out_ready held low 3 cycles mid-stream -> all 10 results 100..109 in order, none lost or duplicated, and in_ready low exactly while out_valid & ~out_ready.
- Reset mid-flight: assert add_rst_n low with 3 beats in the pipe -> outputs 0 immediately (async), no stale result after release. Repeat the basic-add scenario with STAGES=1 and STAGES=8.

Source files
------------

// File: rtl/calc_add_pipe_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// Opcodes, default geometry and segment width derivation.
package calc_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   function automatic int seg_w(input int width, input int stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/calc_add_pipe_if.sv
// Operand/result handshake bundle for calc_add_pipe.
// master drives operands and out_ready; slave is the adder.
interface calc_add_pipe_if #(
   parameter int WIDTH = calc_pkg::DEF_WIDTH
);
   import calc_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, op_sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, op_sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );

endinterface

// File: rtl/calc_add_seg.sv
// One registered carry-chain segment of the pipelined adder.
// Adds a SEG-bit slice plus carry-in; valid travels alongside.
module calc_add_seg import calc_pkg::*; #(
   parameter int SEG = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           en,
   input  logic           vi,
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] sum,
   output logic           co,
   output logic           vo
);

   logic [SEG:0] t;

   assign t = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

   // segment sum, carry and valid advance together when enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
         co  <= 1'b0;
         vo  <= 1'b0;
      end else if (en) begin
         {co, sum} <= t;
         vo        <= vi;
      end
   end

endmodule

// File: rtl/calc_add_pipe.sv
// Pipelined add/sub with segmented carry chain and stall handshake.
// Flags signed overflow and optionally saturates the result.
module calc_add_pipe import calc_pkg::*; #(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter bit SAT    = 1'b0
) (
   input logic            add_clk,
   input logic            add_rst_n,
   calc_add_pipe_if.slave io
);

   localparam int SEG = seg_w(WIDTH, STAGES);

   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // operands still to be summed, shifted so the live slice is at bit 0
   logic [WIDTH-1:0] a_at  [STAGES];
   logic [WIDTH-1:0] b_at  [STAGES];
   // finished lower segments, newest at the top
   logic [WIDTH-1:0] lo_at [STAGES];

   logic [SEG-1:0]   sum [STAGES];
   logic             co  [STAGES];
   logic             vo  [STAGES];

   logic [1:0]       sgn;
   logic [WIDTH-1:0] raw;
   logic             ovf_w;

   assign en          = ~io.out_valid | io.out_ready;
   assign io.in_ready = en;

   assign b_eff = (io.op_sub == OP_SUB) ? ~io.b : io.b;
   assign c0    = (io.op_sub == OP_SUB) ? ~io.cin : io.cin;

   assign a_at[0]  = io.a;
   assign b_at[0]  = b_eff;
   assign lo_at[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic vi_k;
      logic ci_k;

      if (k == 0) begin : g_first
         assign vi_k = io.in_valid;
         assign ci_k = c0;
      end else begin : g_next
         logic [WIDTH-1:0] a_r;
         logic [WIDTH-1:0] b_r;
         logic [WIDTH-1:0] lo_r;

         assign vi_k     = vo[k-1];
         assign ci_k     = co[k-1];
         assign a_at[k]  = a_r;
         assign b_at[k]  = b_r;
         assign lo_at[k] = lo_r;

         // drop the consumed slice; stack the finished segment on top
         always_ff @(posedge add_clk or negedge add_rst_n) begin
            if (!add_rst_n) begin
               a_r  <= '0;
               b_r  <= '0;
               lo_r <= '0;
            end else if (en) begin
               a_r  <= a_at[k-1] >> SEG;
               b_r  <= b_at[k-1] >> SEG;
               lo_r <= WIDTH'({sum[k-1], lo_at[k-1]} >> SEG);
            end
         end
      end

      calc_add_seg #(
         .SEG (SEG)
      ) u_seg (
         .clk   (add_clk),
         .rst_n (add_rst_n),
         .en    (en),
         .vi    (vi_k),
         .a     (a_at[k][SEG-1:0]),
         .b     (b_at[k][SEG-1:0]),
         .ci    (ci_k),
         .sum   (sum[k]),
         .co    (co[k]),
         .vo    (vo[k])
      );
   end

   // operand sign bits captured with the MSB segment for overflow
   always_ff @(posedge add_clk or negedge add_rst_n) begin
      if (!add_rst_n) begin
         sgn <= '0;
      end else if (en) begin
         sgn <= {a_at[STAGES-1][SEG-1], b_at[STAGES-1][SEG-1]};
      end
   end

   assign raw   = WIDTH'({sum[STAGES-1], lo_at[STAGES-1]} >> SEG);
   assign ovf_w = (sgn[1] == sgn[0]) & (raw[WIDTH-1] != sgn[1]);

   assign io.out_valid = vo[STAGES-1];
   assign io.cout      = co[STAGES-1];
   assign io.ovf       = ovf_w;
   assign io.s         = (SAT && ovf_w) ? (sgn[1] ? SMIN : SMAX) : raw;

endmodule

// File: tb/tb_calc_add_pipe.sv
// Bench for calc_add_pipe: four variants against an arithmetic model.
// Directed table, latency, backpressure, reset and random phases.
module tb_calc_add_pipe;

   typedef logic [33:0] res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        d_valid = 1'b0;
   logic [31:0] d_a = '0;
   logic [31:0] d_b = '0;
   logic        d_cin = 1'b0;
   logic        d_sub = 1'b0;
   logic        rdy = 1'b1;

   int checks = 0;
   int failures = 0;
   int out4 = 0;
   bit held = 1'b0;
   bit done = 1'b0;
   logic [34:0] snap = '0;

   res_t q4[$];
   res_t q4s[$];
   res_t q1[$];
   res_t q8[$];

   calc_add_pipe_if #(.WIDTH(32)) i4 ();
   calc_add_pipe_if #(.WIDTH(32)) i4s ();
   calc_add_pipe_if #(.WIDTH(32)) i1 ();
   calc_add_pipe_if #(.WIDTH(32)) i8 ();

   assign i4.in_valid  = d_valid;
   assign i4.a         = d_a;
   assign i4.b         = d_b;
   assign i4.cin       = d_cin;
   assign i4.op_sub    = d_sub;
   assign i4.out_ready = rdy;

   assign i4s.in_valid  = d_valid;
   assign i4s.a         = d_a;
   assign i4s.b         = d_b;
   assign i4s.cin       = d_cin;
   assign i4s.op_sub    = d_sub;
   assign i4s.out_ready = rdy;

   assign i1.in_valid  = d_valid;
   assign i1.a         = d_a;
   assign i1.b         = d_b;
   assign i1.cin       = d_cin;
   assign i1.op_sub    = d_sub;
   assign i1.out_ready = 1'b1;

   assign i8.in_valid  = d_valid;
   assign i8.a         = d_a;
   assign i8.b         = d_b;
   assign i8.cin       = d_cin;
   assign i8.op_sub    = d_sub;
   assign i8.out_ready = 1'b1;

   calc_add_pipe #(.WIDTH(32), .STAGES(4), .SAT(1'b0)) u4 (
      .add_clk   (clk),
      .add_rst_n (rst_n),
      .io        (i4)
   );

   calc_add_pipe #(.WIDTH(32), .STAGES(4), .SAT(1'b1)) u4s (
      .add_clk   (clk),
      .add_rst_n (rst_n),
      .io        (i4s)
   );

   calc_add_pipe #(.WIDTH(32), .STAGES(1), .SAT(1'b0)) u1 (
      .add_clk   (clk),
      .add_rst_n (rst_n),
      .io        (i1)
   );

   calc_add_pipe #(.WIDTH(32), .STAGES(8), .SAT(1'b0)) u8 (
      .add_clk   (clk),
      .add_rst_n (rst_n),
      .io        (i8)
   );

   always #5 clk = ~clk;

   function automatic res_t model(input logic [31:0] a_, input logic [31:0] b_,
                                  input logic ci, input logic sb, input bit sat);
      longint ra, rb, r;
      longint unsigned ua, ub, uc;
      logic [31:0] s_;
      logic co, of;
      ra = longint'($signed(a_));
      rb = longint'($signed(b_));
      ua = {32'b0, a_};
      ub = {32'b0, b_};
      uc = {63'b0, ci};
      if (sb) begin
         r  = ra - rb - longint'(uc);
         co = (ua >= ub + uc);
      end else begin
         r  = ra + rb + longint'(uc);
         co = (ua + ub + uc) > 64'hFFFF_FFFF;
      end
      of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      s_ = r[31:0];
      if (sat && of) s_ = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return {s_, co, of};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic mon(input string nm, input bit sat,
                      input logic iv, input logic ir,
                      input logic [31:0] a_, input logic [31:0] b_,
                      input logic ci, input logic sb,
                      input logic ov, input logic ordy,
                      input logic [31:0] s_, input logic co, input logic of,
                      ref res_t q[$], output bit popped);
      res_t e;
      popped = 1'b0;
      checks++;
      if (ir !== (!ov || ordy)) begin
         failures++;
         $display("FAIL %s_in_ready got=%b want=%b", nm, ir, !ov || ordy);
      end
      if (ov && ordy) begin
         checks++;
         popped = 1'b1;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL %s_spurious got s=%h want no result", nm, s_);
         end else begin
            e = q.pop_front();
            if ({s_, co, of} !== e) begin
               failures++;
               $display("FAIL %s_result got s=%h c=%b v=%b want s=%h c=%b v=%b",
                        nm, s_, co, of, e[33:2], e[1], e[0]);
            end
         end
      end
      if (iv && ir) q.push_back(model(a_, b_, ci, sb, sat));
   endtask

   // compare every DUT against the model and check stall hold on u4
   always @(negedge clk) begin
      bit p;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            checks++;
            if ({i4.out_valid, i4.s, i4.cout, i4.ovf} !== snap) begin
               failures++;
               $display("FAIL s4_hold got=%h want=%h",
                        {i4.out_valid, i4.s, i4.cout, i4.ovf}, snap);
            end
         end
         held = i4.out_valid && !i4.out_ready;
         snap = {i4.out_valid, i4.s, i4.cout, i4.ovf};
         mon("s4", 1'b0, i4.in_valid, i4.in_ready, i4.a, i4.b, i4.cin, i4.op_sub,
             i4.out_valid, i4.out_ready, i4.s, i4.cout, i4.ovf, q4, p);
         if (p) out4++;
         mon("s4sat", 1'b1, i4s.in_valid, i4s.in_ready, i4s.a, i4s.b, i4s.cin,
             i4s.op_sub, i4s.out_valid, i4s.out_ready, i4s.s, i4s.cout, i4s.ovf,
             q4s, p);
         mon("s1", 1'b0, i1.in_valid, i1.in_ready, i1.a, i1.b, i1.cin, i1.op_sub,
             i1.out_valid, i1.out_ready, i1.s, i1.cout, i1.ovf, q1, p);
         mon("s8", 1'b0, i8.in_valid, i8.in_ready, i8.a, i8.b, i8.cin, i8.op_sub,
             i8.out_valid, i8.out_ready, i8.s, i8.cout, i8.ovf, q8, p);
      end
   end

   task automatic send(input logic [31:0] a_, input logic [31:0] b_,
                       input logic ci, input logic sb);
      bit took;
      d_valid = 1'b1;
      d_a = a_;
      d_b = b_;
      d_cin = ci;
      d_sub = sb;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         took = i4.in_ready;
         @(posedge clk);
         #1;
         if (took) begin
            d_valid = 1'b0;
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL send_timeout got in_ready=0 want accept a=%h", a_);
      d_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int t;
      t = 0;
      while ((q4.size() + q4s.size() + q1.size() + q8.size()) != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      chk(nm, 64'(q4.size() + q4s.size() + q1.size() + q8.size()), 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h7FFF_FFFF;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0000;
         default: return $urandom;
      endcase
   endfunction

   task automatic lat_test();
      logic [11:0] v4, v4s, v1, v8;
      v4 = '0;
      v4s = '0;
      v1 = '0;
      v8 = '0;
      d_valid = 1'b1;
      d_a = 32'd50;
      d_b = 32'd13;
      d_cin = 1'b0;
      d_sub = 1'b0;
      @(posedge clk);
      #1;
      d_a = 32'd105;
      d_b = 32'd256;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         v4[c] = i4.out_valid;
         v4s[c] = i4s.out_valid;
         v1[c] = i1.out_valid;
         v8[c] = i8.out_valid;
         @(posedge clk);
         #1;
         if (c == 0) d_valid = 1'b0;
      end
      chk("lat_s4", 64'(v4), 64'h018);
      chk("lat_s4sat", 64'(v4s), 64'h018);
      chk("lat_s1", 64'(v1), 64'h003);
      chk("lat_s8", 64'(v8), 64'h180);
   endtask

   task automatic rand_phase();
      logic [31:0] ra, rb;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               ra = pick();
               rb = pick();
               send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               rdy = ($urandom_range(0, 3) != 0);
            end
            rdy = 1'b1;
         end
      join
   endtask

   initial begin
      int base;
      logic any;

      chk("m_add", 64'(model(32'd50, 32'd13, 1'b0, 1'b0, 1'b0)), {30'b0, 32'd63, 2'b00});
      chk("m_add2", 64'(model(32'd105, 32'd256, 1'b0, 1'b0, 1'b0)), {30'b0, 32'd361, 2'b00});
      chk("m_carry", 64'(model(32'h0000_FFFF, 32'd1, 1'b0, 1'b0, 1'b0)), {30'b0, 32'h0001_0000, 2'b00});
      chk("m_wrap", 64'(model(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0)), {30'b0, 32'h0, 2'b10});
      chk("m_sub", 64'(model(32'd5, 32'd7, 1'b0, 1'b1, 1'b0)), {30'b0, 32'hFFFF_FFFE, 2'b00});
      chk("m_subb", 64'(model(32'd7, 32'd5, 1'b1, 1'b1, 1'b0)), {30'b0, 32'd1, 2'b10});
      chk("m_ovf", 64'(model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0)), {30'b0, 32'h8000_0000, 2'b01});
      chk("m_ovf_sat", 64'(model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1)), {30'b0, 32'h7FFF_FFFF, 2'b01});
      chk("m_uvf", 64'(model(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0)), {30'b0, 32'h7FFF_FFFF, 2'b11});
      chk("m_uvf_sat", 64'(model(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1)), {30'b0, 32'h8000_0000, 2'b11});

      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {29'b0, i4.out_valid, i4.s, i4.cout, i4.ovf}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 64'(i4.in_ready), 64'd1);
      @(posedge clk);
      #1;

      lat_test();
      drain("drain_lat");

      send(32'h0000_FFFF, 32'd1, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
      send(32'd5, 32'd7, 1'b0, 1'b1);
      send(32'd7, 32'd5, 1'b1, 1'b1);
      send(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      send(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      send(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
      drain("drain_dir");

      base = out4;
      fork
         begin
            for (int i = 0; i < 10; i++) send(32'(i), 32'd100, 1'b0, 1'b0);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            rdy = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            rdy = 1'b1;
         end
      join
      drain("drain_bp");
      chk("bp_count", 64'(out4 - base), 64'd10);

      send(32'd1, 32'd10, 1'b0, 1'b0);
      send(32'd2, 32'd10, 1'b0, 1'b0);
      send(32'd3, 32'd10, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      chk("pre_rst_valid", 64'(i4.out_valid), 64'd1);
      rst_n = 1'b0;
      q4.delete();
      q4s.delete();
      q1.delete();
      q8.delete();
      #1;
      chk("rst_async", {29'b0, i4.out_valid, i4.s, i4.cout, i4.ovf}, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      any = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         any = any | i4.out_valid | i4s.out_valid | i1.out_valid | i8.out_valid;
      end
      chk("no_stale", 64'(any), 64'd0);
      @(posedge clk);
      #1;

      rand_phase();
      drain("drain_rand");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
